// File: rtl/tetris_step_engine_if.sv
// Command handshake between the keyboard/gravity pulse logic and tetris_step_engine.
// The master drives commands and the piece selector; the engine answers with cmd_ready.
interface tetris_step_engine_if;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic [2:0] piece_id;

  modport master (output cmd_valid, output cmd, output piece_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input piece_id, output cmd_ready);
endinterface

// File: rtl/tetris_step_engine.sv
// Sequential Tetris step engine: one collision check per cycle, iterative hard drop, row-by-row clear.
// Define TETRIS_SCORE_EN to build the saturating score accumulator; otherwise score_o is tied to zero.
module tetris_step_engine #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int SPAWN_X = 3,
  parameter int SPAWN_Y = -1,
  localparam int XW     = $clog2(COLS + 4) + 1,
  localparam int YW     = $clog2(ROWS + 4) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  tetris_step_engine_if.slave    cmd_if,
  output logic [ROWS*COLS-1:0]   board_o,
  output logic [15:0]            piece_o,
  output logic signed [XW-1:0]   px_o,
  output logic signed [YW-1:0]   py_o,
  output logic                   busy_o,
  output logic                   game_over_o,
  output logic                   clear_pulse_o,
  output logic [2:0]             clear_cnt_o,
  output logic [15:0]            score_o
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  typedef enum logic [2:0] {
    S_OVER, S_READY, S_CHECK, S_DROP, S_LOCK, S_CLEAR, S_SPAWN
  } state_t;

  typedef enum logic [2:0] {
    CMD_START, CMD_CW, CMD_CCW, CMD_LEFT, CMD_RIGHT, CMD_SOFT, CMD_HARD, CMD_TICK
  } cmd_t;

  function automatic logic [15:0] rotCw(input logic [15:0] p);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[4'(4*i+j)] = p[4'(4*(3-j)+i)];
    return r;
  endfunction

  function automatic logic [15:0] rotCcw(input logic [15:0] p);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[4'(4*i+j)] = p[4'(4*j+(3-i))];
    return r;
  endfunction

  function automatic logic [15:0] shapeOf(input logic [2:0] id);
    logic [15:0] s;
    case (id)
      3'd0:    s = 16'b0100_0100_0100_0100;
      3'd1:    s = 16'b0000_0111_0100_0000;
      3'd2:    s = 16'b0000_1110_0010_0000;
      3'd3:    s = 16'b0000_1100_0110_0000;
      3'd4:    s = 16'b0000_0110_1100_0000;
      3'd5:    s = 16'b0000_1110_0100_0000;
      default: s = 16'b0000_0110_0110_0000;
    endcase
    return s;
  endfunction

  // Cells above the board (row < 0) never collide; walls and the floor always do.
  function automatic logic collides(input board_t b, input logic [15:0] p, input int x, input int y);
    logic hitAny;
    int   row;
    int   col;
    hitAny = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        row = y + i;
        col = x + j;
        if (p[4'(4*i+j)]) begin
          if (col < 0 || col >= COLS || row >= ROWS)
            hitAny = 1'b1;
          else if (row >= 0 && b[ROW_W'(row)][COL_W'(col)])
            hitAny = 1'b1;
        end
      end
    return hitAny;
  endfunction

  function automatic board_t maskOf(input logic [15:0] p, input int x, input int y);
    board_t m;
    int     row;
    int     col;
    m = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        row = y + i;
        col = x + j;
        if (p[4'(4*i+j)] && row >= 0 && row < ROWS && col >= 0 && col < COLS)
          m[ROW_W'(row)][COL_W'(col)] = 1'b1;
      end
    return m;
  endfunction

  function automatic logic anyAbove(input logic [15:0] p, input int y);
    logic above;
    above = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (p[4'(4*i+j)] && (y + i) < 0)
          above = 1'b1;
    return above;
  endfunction

  state_t                state_q;
  board_t                board_q;
  logic [15:0]           piece_q;
  logic signed [XW-1:0]  px_q;
  logic signed [YW-1:0]  py_q;
  logic [15:0]           candPiece_q;
  logic signed [XW-1:0]  candPx_q;
  logic signed [YW-1:0]  candPy_q;
  logic                  candFalls_q;
  logic [ROW_W-1:0]      scanRow_q;
  logic [2:0]            clearCount_q;
  logic [2:0]            clearCnt_q;
  logic                  clearPulse_q;

  cmd_t        cmdIn;
  logic        cmdReady;
  logic        accepted;
  logic        startCmd;
  logic [15:0] spawnShape;
  logic [15:0] chkPiece;
  int          chkX;
  int          chkY;
  logic        hit;
  logic        rowFull;
  board_t      lockMask;
  logic        aboveTop;

  assign cmdIn            = cmd_t'(cmd_if.cmd);
  assign cmdReady         = (state_q == S_READY) || (state_q == S_OVER);
  assign cmd_if.cmd_ready = cmdReady;
  assign accepted         = cmd_if.cmd_valid && cmdReady;
  assign startCmd         = accepted && (cmdIn == CMD_START);
  assign spawnShape       = shapeOf(cmd_if.piece_id);
  assign rowFull          = &board_q[scanRow_q];
  assign lockMask         = maskOf(piece_q, int'(px_q), int'(py_q));
  assign aboveTop         = anyAbove(piece_q, int'(py_q));

  // A single collision checker is shared by CHECK, DROP and SPAWN.
  always_comb begin
    chkPiece = candPiece_q;
    chkX     = int'(candPx_q);
    chkY     = int'(candPy_q);
    case (state_q)
      S_DROP: begin
        chkPiece = piece_q;
        chkX     = int'(px_q);
        chkY     = int'(py_q) + 1;
      end
      S_SPAWN: begin
        chkPiece = spawnShape;
        chkX     = SPAWN_X;
        chkY     = SPAWN_Y;
      end
      default: ;
    endcase
    hit = collides(board_q, chkPiece, chkX, chkY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_OVER;
      board_q      <= '0;
      piece_q      <= '0;
      px_q         <= XW'(SPAWN_X);
      py_q         <= YW'(SPAWN_Y);
      candPiece_q  <= '0;
      candPx_q     <= '0;
      candPy_q     <= '0;
      candFalls_q  <= 1'b0;
      scanRow_q    <= '0;
      clearCount_q <= '0;
      clearCnt_q   <= '0;
      clearPulse_q <= 1'b0;
    end else begin
      clearPulse_q <= 1'b0;
      case (state_q)
        S_OVER, S_READY: begin
          if (startCmd) begin
            board_q <= '0;
            state_q <= S_SPAWN;
          end else if (accepted && state_q == S_READY) begin
            candPiece_q <= piece_q;
            candPx_q    <= px_q;
            candPy_q    <= py_q;
            candFalls_q <= 1'b0;
            state_q     <= S_CHECK;
            case (cmdIn)
              CMD_CW:    candPiece_q <= rotCw(piece_q);
              CMD_CCW:   candPiece_q <= rotCcw(piece_q);
              CMD_LEFT:  candPx_q    <= px_q - XW'(1);
              CMD_RIGHT: candPx_q    <= px_q + XW'(1);
              CMD_SOFT, CMD_TICK: begin
                candPy_q    <= py_q + YW'(1);
                candFalls_q <= 1'b1;
              end
              CMD_HARD:  state_q     <= S_DROP;
              default: ;
            endcase
          end
        end
        S_CHECK: begin
          if (!hit) begin
            piece_q <= candPiece_q;
            px_q    <= candPx_q;
            py_q    <= candPy_q;
            state_q <= S_READY;
          end else if (candFalls_q) begin
            state_q <= S_LOCK;
          end else begin
            state_q <= S_READY;
          end
        end
        S_DROP: begin
          if (!hit) py_q    <= py_q + YW'(1);
          else      state_q <= S_LOCK;
        end
        S_LOCK: begin
          if (aboveTop) begin
            state_q <= S_OVER;
          end else begin
            board_q      <= board_q | lockMask;
            scanRow_q    <= ROW_W'(ROWS - 1);
            clearCount_q <= '0;
            state_q      <= S_CLEAR;
          end
        end
        // A full row collapses everything above it; the same row is rescanned next cycle.
        S_CLEAR: begin
          if (rowFull) begin
            for (int k = 1; k < ROWS; k++)
              if (ROW_W'(k) <= scanRow_q)
                board_q[ROW_W'(k)] <= board_q[ROW_W'(k-1)];
            board_q[0]   <= '0;
            clearCount_q <= clearCount_q + 3'd1;
          end else if (scanRow_q == '0) begin
            if (clearCount_q != 3'd0) begin
              clearPulse_q <= 1'b1;
              clearCnt_q   <= clearCount_q;
            end
            state_q <= S_SPAWN;
          end else begin
            scanRow_q <= scanRow_q - ROW_W'(1);
          end
        end
        S_SPAWN: begin
          piece_q <= spawnShape;
          px_q    <= XW'(SPAWN_X);
          py_q    <= YW'(SPAWN_Y);
          state_q <= hit ? S_OVER : S_READY;
        end
        default: state_q <= S_OVER;
      endcase
    end
  end

  assign board_o       = board_q;
  assign piece_o       = piece_q;
  assign px_o          = px_q;
  assign py_o          = py_q;
  assign busy_o        = !cmdReady;
  assign game_over_o   = (state_q == S_OVER);
  assign clear_pulse_o = clearPulse_q;
  assign clear_cnt_o   = clearCnt_q;

`ifdef TETRIS_SCORE_EN
  logic [15:0] score_q;
  logic [3:0]  scoreInc;
  logic [16:0] scoreSum;

  always_comb begin
    case (clearCnt_q)
      3'd1:    scoreInc = 4'd1;
      3'd2:    scoreInc = 4'd3;
      3'd3:    scoreInc = 4'd5;
      3'd4:    scoreInc = 4'd8;
      default: scoreInc = 4'd0;
    endcase
    scoreSum = {1'b0, score_q} + 17'(scoreInc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               score_q <= '0;
    else if (startCmd)     score_q <= '0;
    else if (clearPulse_q) score_q <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
  end

  assign score_o = score_q;
`else
  assign score_o = '0;
`endif

endmodule

// File: tb/tb_tetris_step_engine.sv
// Self-checking bench for tetris_step_engine: directed scenarios plus random commands
// compared against a cell-array game model; honours TETRIS_SCORE_EN for the score.
module tb_tetris_step_engine;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int SPAWN_X = 3;
  localparam int SPAWN_Y = -1;
  localparam int XW      = $clog2(COLS + 4) + 1;
  localparam int YW      = $clog2(ROWS + 4) + 1;

  typedef bit cells_t [4][4];

  logic clk = 1'b0;
  logic rst;
  logic [ROWS*COLS-1:0] board;
  logic [15:0]          piece;
  logic signed [XW-1:0] px;
  logic signed [YW-1:0] py;
  logic                 busy;
  logic                 gameOver;
  logic                 clearPulse;
  logic [2:0]           clearCnt;
  logic [15:0]          score;

  tetris_step_engine_if cmdIf ();

  tetris_step_engine #(
    .COLS(COLS), .ROWS(ROWS), .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y)
  ) dut (
    .clk(clk), .rst(rst), .cmd_if(cmdIf),
    .board_o(board), .piece_o(piece), .px_o(px), .py_o(py),
    .busy_o(busy), .game_over_o(gameOver), .clear_pulse_o(clearPulse),
    .clear_cnt_o(clearCnt), .score_o(score)
  );

  always #5 clk = ~clk;

  int totalChecks  = 0;
  int passedChecks = 0;
  int pulseSeen    = 0;
  bit checkArmed   = 1'b0;

  // Game model: plain cell arrays, whole-command granularity.
  bit     mBoard [ROWS][COLS];
  cells_t mPiece;
  int     mx, my;
  bit     mOver;
  int     mScore;
  int     mPulses;
  int     mLastCnt;

  logic [15:0] shapeTable [8] = '{16'h4444, 16'h0740, 16'h0E20, 16'h0C60,
                                  16'h06C0, 16'h0E40, 16'h0660, 16'h0660};

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void mShape(input int id, output cells_t p);
    logic [15:0] s;
    s = shapeTable[id];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        p[i][j] = s[4*i+j];
  endfunction

  function automatic logic [15:0] packPiece();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        v[4*i+j] = mPiece[i][j];
    return v;
  endfunction

  function automatic logic [ROWS*COLS-1:0] expBoard();
    logic [ROWS*COLS-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[r*COLS+c] = mBoard[r][c];
    return v;
  endfunction

  function automatic bit mCollide(input cells_t p, input int x, input int y);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (p[i][j]) begin
          if (x + j < 0 || x + j >= COLS || y + i >= ROWS) return 1'b1;
          if (y + i >= 0 && mBoard[y+i][x+j]) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic void mRotate(input cells_t a, input bit cw, output cells_t r);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[i][j] = cw ? a[3-j][i] : a[j][3-i];
  endfunction

  function automatic void mSpawn(input int id);
    mShape(id, mPiece);
    mx    = SPAWN_X;
    my    = SPAWN_Y;
    mOver = mCollide(mPiece, mx, my);
  endfunction

  function automatic void mLockAndSpawn(input int id);
    bit nb [ROWS][COLS];
    int dst, cleared, full;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mPiece[i][j] && my + i < 0) begin
          mOver = 1'b1;
          return;
        end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mPiece[i][j]) mBoard[my+i][mx+j] = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        nb[r][c] = 1'b0;
    dst = ROWS - 1;
    cleared = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1;
      for (int c = 0; c < COLS; c++)
        if (!mBoard[r][c]) full = 0;
      if (full != 0) cleared++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = mBoard[r][c];
        dst--;
      end
    end
    mBoard = nb;
    if (cleared > 0) begin
      mPulses++;
      mLastCnt = cleared;
      mScore += (cleared == 1) ? 1 : (cleared == 2) ? 3 : (cleared == 3) ? 5 : 8;
      if (mScore > 65535) mScore = 65535;
    end
    mSpawn(id);
  endfunction

  function automatic void mReset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mBoard[r][c] = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mPiece[i][j] = 1'b0;
    mx = SPAWN_X; my = SPAWN_Y; mOver = 1'b1; mScore = 0; mLastCnt = 0;
  endfunction

  function automatic void modelCmd(input int c, input int id);
    cells_t rot;
    if (c == 0) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++)
          mBoard[r][k] = 1'b0;
      mScore = 0;
      mSpawn(id);
      return;
    end
    if (mOver) return;
    case (c)
      1, 2: begin
        mRotate(mPiece, c == 1, rot);
        if (!mCollide(rot, mx, my)) mPiece = rot;
      end
      3: if (!mCollide(mPiece, mx - 1, my)) mx--;
      4: if (!mCollide(mPiece, mx + 1, my)) mx++;
      6: begin
        while (!mCollide(mPiece, mx, my + 1)) my++;
        mLockAndSpawn(id);
      end
      default: begin
        if (!mCollide(mPiece, mx, my + 1)) my++;
        else mLockAndSpawn(id);
      end
    endcase
  endfunction

  function automatic int expScore();
`ifdef TETRIS_SCORE_EN
    return mScore;
`else
    return 0;
`endif
  endfunction

  // Whenever the engine has settled after a command, every output must match the model.
  always @(negedge clk) begin
    if (clearPulse) pulseSeen++;
    if (checkArmed) begin
      checkOutput("board", board, expBoard());
      checkOutput("piece", piece, packPiece());
      checkOutput("px", int'(px), mx);
      checkOutput("py", int'(py), my);
      checkOutput("game_over", gameOver, mOver);
      checkOutput("cmd_ready", cmdIf.cmd_ready, 1'b1);
      checkOutput("busy", busy, 1'b0);
      checkOutput("clear_cnt", clearCnt, mLastCnt);
      checkOutput("score", score, expScore());
    end
  end

  task automatic applyStimulus(input int c, input int id);
    int  cycles;
    bit  wasOver;
    checkArmed = 1'b0;
    cycles = 0;
    @(negedge clk);
    while (!cmdIf.cmd_ready && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("ready before command", cmdIf.cmd_ready, 1'b1);
    pulseSeen = 0;
    mPulses   = 0;
    wasOver   = mOver;
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd       = 3'(c);
    cmdIf.piece_id  = 3'(id);
    @(posedge clk);
    #1 cmdIf.cmd_valid = 1'b0;
    modelCmd(c, id);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!cmdIf.cmd_ready && cycles < 200);
    checkOutput("ready after command", cmdIf.cmd_ready, 1'b1);
    if (!wasOver && c >= 1 && c <= 4) checkOutput("move latency", cycles, 2);
    checkOutput("clear pulses", pulseSeen, mPulses);
    checkArmed = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkArmed = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd       = '0;
    cmdIf.piece_id  = '0;
    mReset();
    repeat (2) @(negedge clk);
    checkOutput("reset board", board, '0);
    checkOutput("reset piece", piece, '0);
    checkOutput("reset px", int'(px), 3);
    checkOutput("reset py", int'(py), -1);
    checkOutput("reset game_over", gameOver, 1'b1);
    checkOutput("reset clear_cnt", clearCnt, 3'd0);
    checkOutput("reset score", score, 16'd0);
    checkOutput("reset cmd_ready", cmdIf.cmd_ready, 1'b1);
    rst = 1'b0;

    applyStimulus(0, 5);
    checkOutput("T spawn piece", piece, 16'h0E40);
    checkOutput("T spawn px", int'(px), 3);
    checkOutput("T spawn py", int'(py), -1);
    checkOutput("T spawn game_over", gameOver, 1'b0);
    checkOutput("T spawn board", board, '0);
    repeat (5) applyStimulus(3, 5);
    checkOutput("left wall px", int'(px), -1);

    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    checkOutput("I restored", piece, 16'h4444);

    applyStimulus(0, 6);
    applyStimulus(6, 6);
    checkOutput("O drop board", board, (200'd1 << 184) | (200'd1 << 185) | (200'd1 << 194) | (200'd1 << 195));
    checkOutput("O drop no pulse", pulseSeen, 0);

    applyStimulus(0, 0);
    applyStimulus(1, 0);
    repeat (3) applyStimulus(3, 0);
    applyStimulus(6, 0);
    applyStimulus(1, 0);
    applyStimulus(4, 0);
    applyStimulus(6, 6);
    repeat (4) applyStimulus(4, 6);
    applyStimulus(6, 5);
    checkOutput("single clear pulse", pulseSeen, 1);
    checkOutput("single clear cnt", clearCnt, 3'd1);
    checkOutput("single clear board", board, (200'd1 << 198) | (200'd1 << 199));
`ifdef TETRIS_SCORE_EN
    checkOutput("single clear score", score, 16'd1);
`else
    checkOutput("single clear score", score, 16'd0);
`endif

    applyStimulus(0, 6);
    for (int k = 0; k < 15 && !mOver; k++) applyStimulus(6, 6);
    checkOutput("stacked game_over", gameOver, 1'b1);
    checkOutput("stacked cmd_ready", cmdIf.cmd_ready, 1'b1);
    applyStimulus(3, 6);
    applyStimulus(0, 2);
    checkOutput("restart board", board, '0);
    checkOutput("restart game_over", gameOver, 1'b0);

    for (int n = 0; n < 300; n++) begin
      c = mOver ? 0 : $urandom_range(1, 7);
      applyStimulus(c, $urandom_range(0, 7));
    end

    // Reset in the middle of a hard drop must discard everything.
    applyStimulus(0, 0);
    @(negedge clk);
    cmdIf.cmd_valid = 1'b1;
    cmdIf.cmd       = 3'd6;
    @(posedge clk);
    #1 cmdIf.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    mReset();
    checkOutput("mid-drop reset board", board, '0);
    checkOutput("mid-drop reset piece", piece, '0);
    checkOutput("mid-drop reset game_over", gameOver, 1'b1);
    checkOutput("mid-drop reset py", int'(py), -1);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
